pattern_generator: RTL and testbench

- Data-background pattern generator for the programmable memory BIST datapath.
- Produces the write/compare data word for the memory under test from a selected background and the current test address.
- sbmt_in (submit) restarts the background sequence. Each shft_in (shift) strobe advances to the next background.
- Output is registered and feeds the BIST write-data mux and the response comparator.

---
 rtl/pattern_generator.sv | 58 +++++
 tb/tb_pattern_generator.sv | 112 +++++++++++
 2 files changed

// File: rtl/pattern_generator.sv
// pattern_generator: data-background generator for memory BIST write/compare data.
// Backgrounds are selected by a strobe-driven index and may depend on the current address.
module pattern_generator #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sbmt_in,
    input  logic              shft_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [DATA_W-1:0] ptrn_out
);
    localparam logic [DATA_W-1:0] ALT = {(DATA_W/2){2'b01}};
    logic [2:0]        bg_idx_q, bg_idx_d;
    logic              sbmt_q, shft_q;
    logic [DATA_W-1:0] ptrn_q, ptrn_d, addr_ext;
    logic              sbmt_rise, shft_rise;
    if (ADDR_W >= DATA_W) begin : g_trunc
        assign addr_ext = addr_in[DATA_W-1:0];
    end else begin : g_ext
        assign addr_ext = {{(DATA_W-ADDR_W){1'b0}}, addr_in};
    end
    always_comb begin
        sbmt_rise = sbmt_in & ~sbmt_q;
        shft_rise = shft_in & ~shft_q;
        // A high submit level freezes the index, masking any shift edges.
        bg_idx_d  = sbmt_rise ? 3'd0 :
                    sbmt_in   ? bg_idx_q :
                    shft_rise ? bg_idx_q + 3'd1 : bg_idx_q;
        ptrn_d    = '0;
        case (bg_idx_q)
            3'd0: ptrn_d = '0;
            3'd1: ptrn_d = '1;
            3'd2: ptrn_d = ALT;
            3'd3: ptrn_d = ~ALT;
            3'd4: ptrn_d = addr_in[0] ? ~ALT : ALT;
            3'd5: ptrn_d = addr_in[0] ? ALT : ~ALT;
            3'd6: ptrn_d = addr_ext;
            3'd7: ptrn_d = ~addr_ext;
            default: ptrn_d = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bg_idx_q <= 3'd0;
            sbmt_q   <= 1'b0;
            shft_q   <= 1'b0;
            ptrn_q   <= '0;
        end else begin
            bg_idx_q <= bg_idx_d;
            sbmt_q   <= sbmt_in;
            shft_q   <= shft_in;
            ptrn_q   <= ptrn_d;
        end
    end
    assign ptrn_out = ptrn_q;
endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: directed stimulus with a queued scoreboard checked by a separate monitor.
module tb_pattern_generator;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sbmt_in = 1'b0;
    logic       shft_in = 1'b0;
    logic [7:0] addr_in = 8'h3C;
    logic [7:0] ptrn_out;
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];

    pattern_generator #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .sbmt_in(sbmt_in), .shft_in(shft_in),
        .addr_in(addr_in), .ptrn_out(ptrn_out)
    );

    always #5 clk = ~clk;

    function automatic void chk(input logic [7:0] got, input logic [7:0] exp, input string nm);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: ptrn_out=%h expected=%h", nm, got, exp);
        end
    endfunction

    // Each queued entry is the ptrn_out value expected just after the next rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) chk(ptrn_out, exp_q.pop_front(), name_q.pop_front());
    end

    task automatic step(input logic sb, input logic sh, input logic [7:0] a,
                        input logic [7:0] e, input string nm);
        sbmt_in = sb;
        shft_in = sh;
        addr_in = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [7:0] a, input logic [7:0] e0, input logic [7:0] e1, input string nm);
        step(1'b0, 1'b1, a, e0, nm);
        step(1'b0, 1'b0, a, e1, nm);
    endtask

    logic [7:0] walk[9] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'hFE, 8'h00};

    initial begin
        #3 chk(ptrn_out, 8'h00, "rst_async");
        repeat (3) @(posedge clk);
        #2 chk(ptrn_out, 8'h00, "rst_hold");
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h01, 8'h00, "rst_release");
        for (int i = 0; i < 8; i++) pulse(8'h01, walk[i], walk[i+1], "walk");
        pulse(8'h00, 8'h00, 8'hFF, "to_bg4");
        pulse(8'h00, 8'hFF, 8'h55, "to_bg4");
        pulse(8'h00, 8'h55, 8'hAA, "to_bg4");
        pulse(8'h00, 8'hAA, 8'h55, "to_bg4");
        step(1'b0, 1'b0, 8'h01, 8'hAA, "chk_a1");
        step(1'b0, 1'b0, 8'h02, 8'h55, "chk_a2");
        pulse(8'hA7, 8'hAA, 8'h55, "inv_chk");
        pulse(8'hA7, 8'h55, 8'hA7, "addr_data");
        pulse(8'hA7, 8'hA7, 8'h58, "inv_addr");
        pulse(8'hA7, 8'h58, 8'h00, "wrap");
        pulse(8'h00, 8'h00, 8'hFF, "to_bg5");
        pulse(8'h00, 8'hFF, 8'h55, "to_bg5");
        pulse(8'h00, 8'h55, 8'hAA, "to_bg5");
        pulse(8'h00, 8'hAA, 8'h55, "to_bg5");
        pulse(8'h00, 8'h55, 8'hAA, "to_bg5");
        for (int i = 0; i < 11; i++)
            step(1'b1, (i % 2) == 0, 8'h00, (i == 0) ? 8'hAA : 8'h00, "submit_hold");
        step(1'b0, 1'b0, 8'h00, 8'h00, "submit_fall");
        pulse(8'h00, 8'h00, 8'hFF, "after_submit");
        pulse(8'h00, 8'hFF, 8'h55, "to_bg3");
        pulse(8'h00, 8'h55, 8'hAA, "to_bg3");
        step(1'b1, 1'b1, 8'h00, 8'hAA, "simul_edge");
        step(1'b0, 1'b0, 8'h00, 8'h00, "simul_no_inc");
        step(1'b0, 1'b0, 8'h00, 8'h00, "simul_no_inc");
        step(1'b0, 1'b1, 8'h00, 8'h00, "held_shift");
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00, 8'hFF, "held_shift");
        step(1'b0, 1'b0, 8'h00, 8'hFF, "held_once");
        step(1'b0, 1'b0, 8'h00, 8'hFF, "held_once");
        pulse(8'h3C, 8'hFF, 8'h55, "to_bg6");
        pulse(8'h3C, 8'h55, 8'hAA, "to_bg6");
        pulse(8'h3C, 8'hAA, 8'h55, "to_bg6");
        pulse(8'h3C, 8'h55, 8'hAA, "to_bg6");
        pulse(8'h3C, 8'hAA, 8'h3C, "to_bg6");
        rst = 1'b0;
        shft_in = 1'b1;
        #1 chk(ptrn_out, 8'h00, "mid_rst_async");
        @(posedge clk);
        #2 chk(ptrn_out, 8'h00, "mid_rst_hold");
        rst = 1'b1;
        step(1'b0, 1'b1, 8'h3C, 8'h00, "restart");
        step(1'b0, 1'b0, 8'h3C, 8'hFF, "held_through_rst");
        pulse(8'h3C, 8'hFF, 8'h55, "restart_seq");
        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
